// File: rtl/hcms_pkg.sv
// Shared definitions for the HCMS-29xx display path.
// Holds the character-cell geometry, the CW0 control-word layout and its
// reset value, and the render FSM state encoding. The serial driver imports
// this package as well.
package hcms_pkg;

  localparam int CHAR_W     = 5;  // dot columns per character cell
  localparam int GLYPH_ROWS = 7;  // lit rows per column; row 7 is always dark

  // CW0 layout: bit 7 = 0 (selects control word 0), bit 6 = normal operation,
  // bits 5:4 = peak current, bits 3:0 = PWM brightness.
  localparam int          CW0_BRIGHT_LSB = 0;
  localparam int          CW0_PEAK_LSB   = 4;
  localparam int          CW0_NORMAL_BIT = 6;
  localparam logic [7:0]  CW0_RESET      = 8'h4C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_COL    = 2'd2,
    ST_COMMIT = 2'd3
  } render_state_e;

  function automatic logic [7:0] cw0_pack(input logic [1:0] peak,
                                          input logic [3:0] bright);
    logic [7:0] w;
    w                        = '0;
    w[CW0_NORMAL_BIT]        = 1'b1;
    w[CW0_PEAK_LSB +: 2]     = peak;
    w[CW0_BRIGHT_LSB +: 4]   = bright;
    return w;
  endfunction

endpackage

// File: rtl/hcms_font5x7.sv
// 5x7 font ROM, one column per lookup.
// Ports:
//   code     in  8  character code
//   col      in  3  column within the glyph, 0 = leftmost
//   col_bits out 7  column dots, bit 0 = top row
// Printable ASCII 0x20..0x7E returns the standard glyph; every other code
// returns a solid block. Columns beyond the glyph width return 0.
module hcms_font5x7
  import hcms_pkg::*;
(
  input  logic [7:0]            code,
  input  logic [2:0]            col,
  output logic [GLYPH_ROWS-1:0] col_bits
);

  // Glyph packed as five bytes, column 0 in the most significant byte.
  logic [39:0] w_glyph;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    w_glyph = 40'h7F7F7F7F7F;
    case (code)
      8'h20: w_glyph = 40'h0000000000; 8'h21: w_glyph = 40'h00005F0000; 8'h22: w_glyph = 40'h0007000700; 8'h23: w_glyph = 40'h147F147F14;
      8'h24: w_glyph = 40'h242A7F2A12; 8'h25: w_glyph = 40'h2313086462; 8'h26: w_glyph = 40'h3649562050; 8'h27: w_glyph = 40'h0005030000;
      8'h28: w_glyph = 40'h001C224100; 8'h29: w_glyph = 40'h0041221C00; 8'h2A: w_glyph = 40'h14083E0814; 8'h2B: w_glyph = 40'h08083E0808;
      8'h2C: w_glyph = 40'h0050300000; 8'h2D: w_glyph = 40'h0808080808; 8'h2E: w_glyph = 40'h0060600000; 8'h2F: w_glyph = 40'h2010080402;
      8'h30: w_glyph = 40'h3E5149453E; 8'h31: w_glyph = 40'h00427F4000; 8'h32: w_glyph = 40'h4261514946; 8'h33: w_glyph = 40'h2141454B31;
      8'h34: w_glyph = 40'h1814127F10; 8'h35: w_glyph = 40'h2745454539; 8'h36: w_glyph = 40'h3C4A494930; 8'h37: w_glyph = 40'h0171090503;
      8'h38: w_glyph = 40'h3649494936; 8'h39: w_glyph = 40'h064949291E; 8'h3A: w_glyph = 40'h0036360000; 8'h3B: w_glyph = 40'h0056360000;
      8'h3C: w_glyph = 40'h0814224100; 8'h3D: w_glyph = 40'h1414141414; 8'h3E: w_glyph = 40'h0041221408; 8'h3F: w_glyph = 40'h0201510906;
      8'h40: w_glyph = 40'h324979413E; 8'h41: w_glyph = 40'h7E1111117E; 8'h42: w_glyph = 40'h7F49494936; 8'h43: w_glyph = 40'h3E41414122;
      8'h44: w_glyph = 40'h7F4141221C; 8'h45: w_glyph = 40'h7F49494941; 8'h46: w_glyph = 40'h7F09090901; 8'h47: w_glyph = 40'h3E4149497A;
      8'h48: w_glyph = 40'h7F0808087F; 8'h49: w_glyph = 40'h00417F4100; 8'h4A: w_glyph = 40'h2040413F01; 8'h4B: w_glyph = 40'h7F08142241;
      8'h4C: w_glyph = 40'h7F40404040; 8'h4D: w_glyph = 40'h7F020C027F; 8'h4E: w_glyph = 40'h7F0408107F; 8'h4F: w_glyph = 40'h3E4141413E;
      8'h50: w_glyph = 40'h7F09090906; 8'h51: w_glyph = 40'h3E4151215E; 8'h52: w_glyph = 40'h7F09192946; 8'h53: w_glyph = 40'h4649494931;
      8'h54: w_glyph = 40'h01017F0101; 8'h55: w_glyph = 40'h3F4040403F; 8'h56: w_glyph = 40'h1F2040201F; 8'h57: w_glyph = 40'h3F4038403F;
      8'h58: w_glyph = 40'h6314081463; 8'h59: w_glyph = 40'h0708700807; 8'h5A: w_glyph = 40'h6151494543; 8'h5B: w_glyph = 40'h007F414100;
      8'h5C: w_glyph = 40'h0204081020; 8'h5D: w_glyph = 40'h0041417F00; 8'h5E: w_glyph = 40'h0402010204; 8'h5F: w_glyph = 40'h4040404040;
      8'h60: w_glyph = 40'h0001020400; 8'h61: w_glyph = 40'h2054545478; 8'h62: w_glyph = 40'h7F48444438; 8'h63: w_glyph = 40'h3844444420;
      8'h64: w_glyph = 40'h384444487F; 8'h65: w_glyph = 40'h3854545418; 8'h66: w_glyph = 40'h087E090102; 8'h67: w_glyph = 40'h0C5252523E;
      8'h68: w_glyph = 40'h7F08040478; 8'h69: w_glyph = 40'h00447D4000; 8'h6A: w_glyph = 40'h2040443D00; 8'h6B: w_glyph = 40'h7F10284400;
      8'h6C: w_glyph = 40'h00417F4000; 8'h6D: w_glyph = 40'h7C04180478; 8'h6E: w_glyph = 40'h7C08040478; 8'h6F: w_glyph = 40'h3844444438;
      8'h70: w_glyph = 40'h7C14141408; 8'h71: w_glyph = 40'h081414187C; 8'h72: w_glyph = 40'h7C08040408; 8'h73: w_glyph = 40'h4854545420;
      8'h74: w_glyph = 40'h043F444020; 8'h75: w_glyph = 40'h3C4040207C; 8'h76: w_glyph = 40'h1C2040201C; 8'h77: w_glyph = 40'h3C4030403C;
      8'h78: w_glyph = 40'h4428102844; 8'h79: w_glyph = 40'h0C5050503C; 8'h7A: w_glyph = 40'h4464544C44; 8'h7B: w_glyph = 40'h0008364100;
      8'h7C: w_glyph = 40'h00007F0000; 8'h7D: w_glyph = 40'h0041360800; 8'h7E: w_glyph = 40'h1008081008;
      default: w_glyph = 40'h7F7F7F7F7F;
    endcase

    col_bits = '0;
    if (int'(col) < CHAR_W)
      col_bits = w_glyph[(CHAR_W - 1 - int'(col)) * 8 +: GLYPH_ROWS];
  end

endmodule

// File: rtl/hcms_text_render.sv
// Text-buffer renderer feeding the HCMS-29xx serial driver.
// Holds NCHARS ASCII cells, renders them column by column through the 5x7
// font into a shadow dot vector, and commits that vector plus the CW0 control
// word to the outputs in a single cycle.
// Ports:
//   clk, rst (sync, active-high)
//   wr_en/wr_addr/wr_char  text buffer write port, accepted every cycle
//   refresh_req            render request (pulse or level)
//   bright, peak           CW0 fields, sampled at commit
//   busy                   render in progress
//   frame_valid            one-cycle pulse when new outputs are committed
//   pdata_out              dot vector, cell c column k row r at ((c*CHAR_W+k)*UNIT_H+r)
//   pcmd_out               CW0 = {0, 1, peak, bright}
// Build option: TEXT_AUTO_REFRESH_EN makes every buffer write request a render.
module hcms_text_render #(
  parameter  int N      = 2,
  parameter  int UNIT_W = 20,
  parameter  int UNIT_H = 8,
  parameter  int CHAR_W = hcms_pkg::CHAR_W,
  localparam int NCHARS = N * UNIT_W / CHAR_W,
  localparam int ADDR_W = (NCHARS > 1) ? $clog2(NCHARS) : 1,
  localparam int PD_W   = N * UNIT_W * UNIT_H
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              refresh_req,
  input  logic [3:0]        bright,
  input  logic [1:0]        peak,
  output logic              busy,
  output logic              frame_valid,
  output logic [PD_W-1:0]   pdata_out,
  output logic [7:0]        pcmd_out
);
  import hcms_pkg::*;

  localparam int OFF_W = $clog2(PD_W);

  render_state_e         r_state, w_state_nxt;
  logic                  r_pending;
  logic [ADDR_W-1:0]     r_cell;
  logic [2:0]            r_col;
  logic [7:0]            r_code;
  logic [7:0]            r_text [NCHARS];
  logic [PD_W-1:0]       r_shadow;

  logic                  w_start, w_fetch, w_col_wr, w_commit, w_req_wr;
  logic [GLYPH_ROWS-1:0] w_col_bits;
  logic [OFF_W-1:0]      w_off;

`ifdef TEXT_AUTO_REFRESH_EN
  assign w_req_wr = wr_en;
`else
  assign w_req_wr = 1'b0;
`endif

  hcms_font5x7 u_font (
    .code     (r_code),
    .col      (r_col),
    .col_bits (w_col_bits)
  );

  assign w_off = OFF_W'((int'(r_cell) * CHAR_W + int'(r_col)) * UNIT_H);
  assign busy  = (r_state != ST_IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_fetch     = 1'b0;
    w_col_wr    = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Requests are always captured in r_pending first, which gives the
        // fixed one-cycle gap between the request edge and FETCH.
        if (r_pending) begin
          w_start     = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_fetch     = 1'b1;
        w_state_nxt = ST_COL;
      end
      ST_COL: begin
        w_col_wr = 1'b1;
        if (int'(r_col) == CHAR_W - 1)
          w_state_nxt = (int'(r_cell) == NCHARS - 1) ? ST_COMMIT : ST_FETCH;
      end
      ST_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_cell      <= '0;
      r_col       <= '0;
      r_code      <= 8'h20;
      frame_valid <= 1'b0;
      pdata_out   <= '0;
      pcmd_out    <= CW0_RESET;
      for (int i = 0; i < NCHARS; i++) r_text[i] <= 8'h20;
    end else begin
      frame_valid <= w_commit;

      // Starting a render consumes every request seen so far, so any number
      // of requests during a render collapse into one follow-up.
      if (w_start)                      r_pending <= 1'b0;
      else if (refresh_req || w_req_wr) r_pending <= 1'b1;

      if (w_start) r_cell <= '0;
      if (w_fetch) begin
        r_code <= r_text[r_cell];  // pre-edge value: a same-cycle write lands next frame
        r_col  <= '0;
      end
      if (w_col_wr) begin
        r_col <= r_col + 3'd1;
        if (int'(r_col) == CHAR_W - 1) r_cell <= r_cell + 1'b1;
      end

      if (w_commit) begin
        pdata_out <= r_shadow;
        pcmd_out  <= cw0_pack(peak, bright);
      end

      if (wr_en && (int'(wr_addr) < NCHARS)) r_text[wr_addr] <= wr_char;
    end
  end

  // NOTE: the shadow vector has no reset; every column is rewritten before a
  // commit can expose it, so its power-up contents never reach the outputs.
  always_ff @(posedge clk) begin
    if (w_col_wr) r_shadow[w_off +: UNIT_H] <= UNIT_H'(w_col_bits);
  end

endmodule
